// File: rtl/tt_checker.sv
// Exhaustive truth-table checker: sweeps {a,b,c,d} through 0..15, holds each
// vector HOLD cycles, samples f on the last cycle and tallies mismatches.
module tt_checker #(
    parameter logic [15:0] EXPECT = 16'h0000,
    parameter int unsigned HOLD   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       first_err_valid,
    output logic [3:0] first_err_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_e     state_q, state_d;
    logic [3:0] idx_q,   idx_d;
    logic [7:0] hold_q,  hold_d;
    logic [3:0] vec_q,   vec_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;
    logic       pass_q,  pass_d;
    logic [4:0] err_q,   err_d;
    logic       fev_q,   fev_d;
    logic [3:0] fei_q,   fei_d;
    logic       sample;
    logic       mismatch;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        vec_d    = vec_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fev_d    = fev_q;
        fei_d    = fei_q;
        sample   = (state_q == RUN) && (hold_q == HOLD_LAST);
        mismatch = sample && (f != EXPECT[idx_q]);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = 4'd0;
                    hold_d  = 8'd0;
                    vec_d   = 4'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 5'd0;
                    fev_d   = 1'b0;
                    fei_d   = 4'd0;
                end
            end
            RUN: begin
                if (mismatch) begin
                    err_d = err_q + 5'd1;
                    if (!fev_q) begin
                        fev_d = 1'b1;
                        fei_d = idx_q;
                    end
                end
                if (sample) begin
                    hold_d = 8'd0;
                    if (idx_q == 4'd15) begin
                        // pass uses err_d so the final compare is already folded in
                        state_d = DONE;
                        idx_d   = 4'd0;
                        vec_d   = 4'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 5'd0);
                    end else begin
                        idx_d = idx_q + 4'd1;
                        vec_d = idx_q + 4'd1;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            hold_q  <= 8'd0;
            vec_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 5'd0;
            fev_q   <= 1'b0;
            fei_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fei_q   <= fei_d;
        end
    end

    assign {a, b, c, d}    = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_tt_checker.sv
// Bench for tt_checker: four instances with different EXPECT/HOLD, each driven
// by a behavioural truth table; results checked against a table-diff model.
module tb_tt_checker;

    localparam logic [3:0][15:0] EXPS  = {16'hA5C3, 16'h0000, 16'h00F0, 16'h0F3C};
    localparam logic [3:0][7:0]  HOLDS = {8'd3, 8'd1, 8'd2, 8'd2};

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      start  = '0;
    logic [3:0]      glitch = '0;
    logic [3:0]      f, a, b, c, d, busy, done, pass, fev;
    logic [3:0][4:0] errc;
    logic [3:0][3:0] fei;
    logic [15:0]     ftab [4];
    int              n_cmp = 0;
    int              n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_u
        assign f[g] = ftab[g][{a[g], b[g], c[g], d[g]}] ^ glitch[g];
        tt_checker #(.EXPECT(EXPS[g]), .HOLD(int'(HOLDS[g]))) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .f(f[g]),
            .a(a[g]), .b(b[g]), .c(c[g]), .d(d[g]),
            .busy(busy[g]), .done(done[g]), .pass(pass[g]),
            .err_count(errc[g]), .first_err_valid(fev[g]), .first_err_idx(fei[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int vec_of(input int u);
        return int'({a[u], b[u], c[u], d[u]});
    endfunction

    // mismatches among the first n vectors of the sweep
    function automatic int count_bad(input logic [15:0] bad, input int n);
        int k = 0;
        for (int i = 0; i < n; i++) if (bad[i]) k++;
        return k;
    endfunction

    function automatic int first_bad(input logic [15:0] bad, input int n);
        for (int i = 0; i < n; i++) if (bad[i]) return i;
        return -1;
    endfunction

    task automatic check_idle(input string tag, input int u);
        chk({tag, "_busy"}, busy[u], 0);
        chk({tag, "_done"}, done[u], 0);
        chk({tag, "_outs"}, {a[u], b[u], c[u], d[u], pass[u], fev[u], errc[u], fei[u]}, 0);
    endtask

    task automatic sweep(input int u, input logic [15:0] tab, input bit glitchy, input int start_at);
        int          h;
        int          nv;
        int          fe;
        logic [15:0] bad;
        h       = int'(HOLDS[u]);
        ftab[u] = tab;
        bad     = tab ^ EXPS[u];
        @(negedge clk);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        for (int cyc = 0; cyc < 16 * h; cyc++) begin
            nv = cyc / h;
            chk("run_busy", busy[u], 1);
            chk("run_done", done[u], 0);
            chk("run_pass", pass[u], 0);
            chk("run_vec", vec_of(u), nv);
            chk("run_err", errc[u], count_bad(bad, nv));
            fe = first_bad(bad, nv);
            chk("run_fev", fev[u], (fe >= 0) ? 1 : 0);
            if (fe >= 0) chk("run_fei", fei[u], fe);
            start[u]  = (start_at >= 0) && (cyc == start_at * h);
            glitch[u] = glitchy && ((cyc % h) != (h - 1));
            @(negedge clk);
        end
        start[u]  = 1'b0;
        glitch[u] = 1'b0;
        fe = first_bad(bad, 16);
        for (int k = 0; k < 2; k++) begin
            chk("done_busy", busy[u], 0);
            chk("done_done", done[u], 1);
            chk("done_vec", vec_of(u), 0);
            chk("done_err", errc[u], count_bad(bad, 16));
            chk("done_pass", pass[u], (count_bad(bad, 16) == 0) ? 1 : 0);
            chk("done_fev", fev[u], (fe >= 0) ? 1 : 0);
            chk("done_fei", fei[u], (fe >= 0) ? fe : 0);
            @(negedge clk);
        end
    endtask

    task automatic mid_reset();
        int guard = 0;
        ftab[0] = EXPS[0] ^ 16'h0041;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        while (vec_of(0) != 7 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("pre_rst_vec", vec_of(0), 7);
        chk("pre_rst_err", errc[0], 2);
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_rst", 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("post_rst", 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] mask;
        int          u;
        for (int i = 0; i < 4; i++) ftab[i] = 16'h0000;
        #1;
        for (int i = 0; i < 4; i++) check_idle("reset", i);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) check_idle("idle", i);

        sweep(0, EXPS[0], 1'b0, -1);              // matching block
        sweep(1, 16'h0000, 1'b0, -1);             // stuck low
        sweep(2, 16'hFFFF, 1'b0, -1);             // stuck high, HOLD=1
        sweep(0, EXPS[0] ^ 16'h0300, 1'b0, 5);    // start ignored in RUN
        sweep(0, EXPS[0], 1'b0, -1);              // restart from DONE clears
        sweep(3, EXPS[3], 1'b1, -1);              // HOLD=3 glitches ignored
        sweep(3, EXPS[3] ^ 16'h8001, 1'b1, 2);
        mid_reset();
        sweep(0, EXPS[0] ^ 16'h8000, 1'b0, -1);

        for (int r = 0; r < 20; r++) begin
            u = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0:       mask = 16'h0000;
                1:       mask = 16'(1 << $urandom_range(0, 15));
                default: mask = 16'($urandom);
            endcase
            sweep(u, EXPS[u] ^ mask, (HOLDS[u] > 1) && ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 15)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tt_checker.md
TT_CHECKER -- requirements
Module: tt_checker

Interface
REQ-001 The block SHALL use one clock; reset SHALL be asynchronous and active-low; ports SHALL be named clk and rst_n.
REQ-002 Parameter EXPECT, default 16'h0000: golden truth table, where bit i is the expected f for input vector i = {a,b,c,d}, with a as MSB.
REQ-003 Parameter HOLD, default 2: clock cycles each vector is held; legal range 1..255.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin a sweep.
REQ-007 f  input  1  response from the combinational block under check.
REQ-008 a, b, c, d  output  1 each  stimulus driven to the block under check.
REQ-009 busy  output  1  high while a sweep is running.
REQ-010 done  output  1  high once a sweep has completed; held until the next start.
REQ-011 pass  output  1  high when done=1 and no mismatch was recorded.
REQ-012 err_count  output  5  number of mismatching vectors, 0..16.
REQ-013 first_err_valid  output  1  high once at least one mismatch has been recorded.
REQ-014 first_err_idx  output  4  index of the first mismatching vector.

Function
REQ-015 The block SHALL implement three states: IDLE, RUN, DONE.
REQ-016 IDLE, start=1: go to RUN next edge; idx=0; hold counter=0; err_count=0; first_err_valid=0; first_err_idx=0.
REQ-017 RUN: {a,b,c,d} SHALL equal idx (registered); busy=1; done=0; pass=0.
REQ-018 RUN: the hold counter SHALL increment each cycle from 0 to HOLD-1.
REQ-019 On the edge where hold counter=HOLD-1, f SHALL be sampled and compared with EXPECT[idx].
REQ-020 Mismatch: err_count SHALL increment by 1; if first_err_valid=0, first_err_idx SHALL take idx and first_err_valid SHALL be set to 1.
REQ-021 After the sample: if idx=15, go to DONE; otherwise idx increments and the hold counter returns to 0. idx SHALL NOT wrap within a sweep.
REQ-022 A sweep SHALL last exactly 16*HOLD cycles in RUN; done SHALL rise on the edge of the 16th sample, with the final compare already included in err_count.
REQ-023 DONE: a,b,c,d=0; busy=0; done=1; pass=(err_count==0); err_count and the first_err fields SHALL be held.
REQ-024 DONE, start=1: restart exactly as from IDLE (REQ-016).
REQ-025 start SHALL be ignored while in RUN.
REQ-026 HOLD=1: every RUN cycle SHALL be a sample cycle.
REQ-027 err_count SHALL be 5 bits wide so that 16 mismatches are represented without overflow.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE and set all outputs and internal counters to 0 (a,b,c,d, busy, done, pass, err_count, first_err_valid, first_err_idx).
REQ-029 Reset asserted mid-sweep SHALL abort the sweep with no partial result retained; a new start is required after release.
REQ-030 After rst_n rises, the first edge SHALL evaluate normally.

Verification
REQ-031 The bench SHALL cover each scenario below.
- Matching model: EXPECT=16'h0F3C, HOLD=2, f = EXPECT[{a,b,c,d}] via behavioural lookup, start pulse -> busy for 32 cycles; vectors 0..15 in order, 2 cycles each; then done=1, pass=1, err_count=0, first_err_valid=0.
- Output stuck low: f tied 0, EXPECT=16'h00F0 -> err_count=4, first_err_idx=4, first_err_valid=1, pass=0.
- Output stuck high: f tied 1, EXPECT=16'h0000, HOLD=1 -> err_count=16 (5'b10000), first_err_idx=0, done 16 cycles after start.
- Start handling: start pulsed at idx=5 during RUN -> no effect, sweep finishes normally; start pulsed in DONE -> counters clear, sweep restarts at idx=0.
- Mid-sweep reset: rst_n=0 at idx=7 between clock edges -> all outputs 0 before the next edge; after release, idle until start.
- Timing: HOLD=3 -> each vector stable for exactly 3 cycles; f is sampled only on the third cycle, and a glitch on f in cycles 1-2 is not counted.
